// File: rtl/cordic_unit.sv
// Iterative CORDIC engine: vectoring (magnitude/angle) or rotation of a 2-D vector,
// one micro-rotation per cycle, followed by a single gain-compensation/saturation cycle.
// FRAC must not exceed 16: the angle and gain constants derive from a 2^-16 table.
module cordic_unit #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int ITER  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             ovf
);

    localparam int XW = WIDTH + 2;
    localparam int ZW = WIDTH + 1;
    localparam int PW = XW + FRAC + 2;
    localparam int CW = 5;

    // atan(2^-i) scaled by 2^16, rounded.
    function automatic int atan16(input int i);
        case (i)
            0:       return 51472;
            1:       return 30386;
            2:       return 16055;
            3:       return 8150;
            4:       return 4091;
            5:       return 2047;
            6:       return 1024;
            7:       return 512;
            8:       return 256;
            9:       return 128;
            10:      return 64;
            11:      return 32;
            12:      return 16;
            13:      return 8;
            14:      return 4;
            15:      return 2;
            default: return 0;
        endcase
    endfunction

    // Rescale a 2^-16 constant to 2^-FRAC with round-half-up.
    function automatic int to_frac(input int v);
        if (FRAC >= 16) begin
            return v;
        end else begin
            return (v + (1 << (15 - FRAC))) >>> (16 - FRAC);
        end
    endfunction

    localparam int PI_I = to_frac(205887);
    localparam int HALF_I = PI_I / 2;
    localparam int K_I = to_frac(39797);

    localparam logic signed [ZW-1:0] PI_Z    = ZW'(PI_I);
    localparam logic signed [ZW-1:0] HALF_Z  = ZW'(HALF_I);
    localparam logic signed [PW-1:0] K_P     = PW'(K_I);
    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StIdle, StIter, StGain, StDone} state_e;

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic [CW-1:0]        i_q, i_d;
    logic [WIDTH-1:0]     xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
    logic                 ovf_q, ovf_d;

    logic signed [XW-1:0] xi, yi;
    logic signed [ZW-1:0] zi, atan_c;
    logic signed [PW-1:0] px, py, sx, sy;
    logic                 ccw;
    logic signed [ZW-1:0] atan_tab [16];

    for (genvar g = 0; g < 16; g++) begin : g_atan
        assign atan_tab[g] = ZW'(to_frac(atan16(g)));
    end

    assign xi = {{2{x_in[WIDTH-1]}}, x_in};
    assign yi = {{2{y_in[WIDTH-1]}}, y_in};
    assign zi = {z_in[WIDTH-1], z_in};

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign x_out     = xo_q;
    assign y_out     = yo_q;
    assign z_out     = zo_q;
    assign ovf       = ovf_q;

    // Next-state: operand load with quadrant correction, micro-rotations, gain and handoff.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        ovf_d   = ovf_q;
        atan_c  = atan_tab[i_q[3:0]];
        // Both modes share one rotation form; only the direction criterion differs.
        ccw     = mode_q ? (z_q >= 0) : (y_q < 0);
        px      = PW'(x_q) * K_P;
        py      = PW'(y_q) * K_P;
        sx      = px >>> FRAC;
        sy      = py >>> FRAC;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StIter;
                    mode_d  = mode;
                    i_d     = '0;
                    ovf_d   = 1'b0;
                    if (mode) begin
                        if (zi > HALF_Z) begin
                            x_d = -yi;
                            y_d = xi;
                            z_d = zi - HALF_Z;
                        end else if (zi < -HALF_Z) begin
                            x_d = yi;
                            y_d = -xi;
                            z_d = zi + HALF_Z;
                        end else begin
                            x_d = xi;
                            y_d = yi;
                            z_d = zi;
                        end
                    end else if (xi < 0) begin
                        x_d = -xi;
                        y_d = -yi;
                        z_d = (yi >= 0) ? PI_Z : -PI_Z;
                    end else begin
                        x_d = xi;
                        y_d = yi;
                        z_d = '0;
                    end
                end
            end
            StIter: begin
                if (i_q == CW'(ITER)) begin
                    state_d = StGain;
                end else begin
                    i_d = i_q + 1'b1;
                    if (ccw) begin
                        x_d = x_q - (y_q >>> i_q);
                        y_d = y_q + (x_q >>> i_q);
                        z_d = z_q - atan_c;
                    end else begin
                        x_d = x_q + (y_q >>> i_q);
                        y_d = y_q - (x_q >>> i_q);
                        z_d = z_q + atan_c;
                    end
                end
            end
            StGain: begin
                state_d = StDone;
                zo_d    = z_q[WIDTH-1:0];
                if (sx > SAT_MAX) begin
                    xo_d  = SAT_MAX[WIDTH-1:0];
                    ovf_d = 1'b1;
                end else if (sx < SAT_MIN) begin
                    xo_d  = SAT_MIN[WIDTH-1:0];
                    ovf_d = 1'b1;
                end else begin
                    xo_d = sx[WIDTH-1:0];
                end
                if (sy > SAT_MAX) begin
                    yo_d  = SAT_MAX[WIDTH-1:0];
                    ovf_d = 1'b1;
                end else if (sy < SAT_MIN) begin
                    yo_d  = SAT_MIN[WIDTH-1:0];
                    ovf_d = 1'b1;
                end else begin
                    yo_d = sy[WIDTH-1:0];
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
